// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush and memory-wait
// stalling with a timeout error state and a saturating stall counter.
module pipe_ctrl #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_memread,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cnt_q;
    logic        mem_timeout_q;
    logic        mem_stall;
    logic        load_use;

    always_comb begin
        mem_stall = (state_q != StErr) && dmem_req && !dmem_ack;
        load_use  = idex_memread && (idex_rd != '0) &&
                    ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
    end

    // Priority: ERR / memory wait, then taken branch, then load-use bubble.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (!reset) begin
            if ((state_q == StErr) || mem_stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_flush = 1'b1;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun, StWait: begin
                if (mem_stall) begin
                    if (wait_cnt_q == TimeoutLast) begin
                        state_d    = StErr;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end
            end
            StErr: begin
                state_d    = StErr;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_q || (state_d == StErr);
            if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the combinational priority
// plus hand sequences for memory waits, timeout and reset.
module tb_pipe_ctrl;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] ifid_rs1, ifid_rs2, idex_rd;
    logic             ifid_use_rs1, ifid_use_rs2, idex_memread;
    logic             ex_branch_taken, dmem_req, dmem_ack;
    logic             pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic             ifid_flush, idex_flush, memwb_flush, mem_timeout;
    logic [31:0]      stall_cnt;
    logic [6:0]       outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .ifid_rs1        (ifid_rs1),
        .ifid_rs2        (ifid_rs2),
        .ifid_use_rs1    (ifid_use_rs1),
        .ifid_use_rs2    (ifid_use_rs2),
        .idex_rd         (idex_rd),
        .idex_memread    (idex_memread),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ack        (dmem_ack),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .idex_stall      (idex_stall),
        .exmem_stall     (exmem_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_flush     (memwb_flush),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt)
    );

    // {pc, ifid_s, idex_s, exmem_s, ifid_f, idex_f, memwb_f}
    assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                   ifid_flush, idex_flush, memwb_flush};

    localparam logic [6:0] O_NONE = 7'b000_0000;
    localparam logic [6:0] O_MEM  = 7'b111_1001;
    localparam logic [6:0] O_BR   = 7'b000_0110;
    localparam logic [6:0] O_LU   = 7'b110_0010;

    typedef struct {
        logic [REG_W-1:0] rs1, rs2, rd;
        logic             use1, use2, memread, br, req, ack;
        logic [6:0]       exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
        ifid_use_rs1 = 0; ifid_use_rs2 = 0; idex_memread = 0;
        ex_branch_taken = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rs1 rs2 rd u1 u2 mr br rq ak  exp
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, O_NONE};
        vecs[1]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, O_LU};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, O_NONE};
        vecs[3]  = '{5'd7, 5'd0, 5'd7, 1, 0, 1, 1, 0, 0, O_BR};
        vecs[4]  = '{5'd7, 5'd0, 5'd7, 0, 0, 1, 0, 0, 0, O_NONE};
        vecs[5]  = '{5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 0, 0, O_NONE};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, O_MEM};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1, O_BR};
        vecs[8]  = '{5'd3, 5'd0, 5'd3, 1, 0, 1, 1, 1, 0, O_MEM};
        vecs[9]  = '{5'd0, 5'd9, 5'd9, 0, 1, 1, 0, 0, 0, O_LU};
        vecs[10] = '{5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0, 0, O_BR};

        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_outs", 32'(outs), 32'(O_NONE));
        reset = 1'b0;
        #1;
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_timeout", 32'(mem_timeout), 32'd0);

        // Single load-use cycle bumps the counter by exactly one.
        @(negedge clk);
        idex_memread = 1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_use_rs2 = 1;
        #1;
        chk("lu_outs", 32'(outs), 32'(O_LU));
        chk("lu_cnt_before", stall_cnt, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("lu_cnt_after", stall_cnt, 32'd1);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ifid_rs1 = vecs[i].rs1; ifid_rs2 = vecs[i].rs2; idex_rd = vecs[i].rd;
            ifid_use_rs1 = vecs[i].use1; ifid_use_rs2 = vecs[i].use2;
            idex_memread = vecs[i].memread; ex_branch_taken = vecs[i].br;
            dmem_req = vecs[i].req; dmem_ack = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
        end

        // Three-cycle memory wait, zero-cycle release on ack.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_req = 1; dmem_ack = 0;
            #1;
            chk($sformatf("wait%0d", i), 32'(outs), 32'(O_MEM));
        end
        @(negedge clk);
        dmem_ack = 1;
        #1;
        chk("ack_release", 32'(outs), 32'(O_NONE));
        @(negedge clk);
        dmem_req = 0; dmem_ack = 0;
        #1;
        chk("wait_stall_cnt", stall_cnt, 32'd3);
        chk("wait_no_timeout", 32'(mem_timeout), 32'd0);

        // TIMEOUT-1 stalled cycles must not trip the error.
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            @(negedge clk);
            dmem_req = 1; dmem_ack = 0;
        end
        @(negedge clk);
        dmem_req = 0;
        #1;
        chk("near_timeout", 32'(mem_timeout), 32'd0);

        // Full TIMEOUT stalled cycles enter ERR.
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            dmem_req = 1; dmem_ack = 0;
            #1;
            if (i == TIMEOUT - 1) chk("timeout_pre", 32'(mem_timeout), 32'd0);
        end
        @(negedge clk);
        dmem_ack = 1; ex_branch_taken = 1;
        #1;
        chk("timeout_set", 32'(mem_timeout), 32'd1);
        chk("err_outs", 32'(outs), 32'(O_MEM));
        chk("err_stall_cnt", stall_cnt, 32'd34);
        @(negedge clk);
        dmem_req = 0; dmem_ack = 0; ex_branch_taken = 0;
        #1;
        chk("err_sticky", 32'(mem_timeout), 32'd1);
        chk("err_sticky_outs", 32'(outs), 32'(O_MEM));

        @(negedge clk);
        reset = 1; dmem_req = 1; dmem_ack = 0; ex_branch_taken = 1;
        #1;
        chk("reset_gates_outs", 32'(outs), 32'(O_NONE));
        @(negedge clk);
        reset = 0; idle_inputs();
        #1;
        chk("reset_clr_timeout", 32'(mem_timeout), 32'd0);
        chk("reset_clr_cnt", stall_cnt, 32'd0);
        chk("reset_run_outs", 32'(outs), 32'(O_NONE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
